// File: rtl/dmem_access_ctrl_if.sv
// CPU-side request/response and data-RAM bus of the data-memory access controller.
// The controller uses the master modport; the pipeline/RAM side uses slave.
interface dmem_access_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;

    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_done, cpu_err,
        output mem_cs, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_done, cpu_err,
        input  mem_cs, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-RAM access controller: latches one MEM-stage load/store, holds the RAM bus stable
// until ack (or timeout), then parks the address so the RAM's change detector re-arms.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT    = 32,
    parameter logic [31:0] PARK_ADDR  = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_access_ctrl_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE,
        DONE
    } state_e;

    state_e           state_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_cs_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_din_q;
    logic [31:0]      rdata_q;
    logic             done_q;
    logic             err_q;
    logic             addr_ok;

    assign addr_ok = (bus.cpu_addr >> ADDR_WIDTH) == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= PARK_ADDR;
            mem_din_q  <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we_q  <= bus.cpu_we;
                        cnt_q <= '0;
                        if (addr_ok) begin
                            state_q    <= ACCESS;
                            mem_cs_q   <= 1'b1;
                            mem_we_q   <= bus.cpu_we;
                            mem_addr_q <= bus.cpu_addr;
                            mem_din_q  <= bus.cpu_wdata;
                        end else begin
                            // Rejected address never reaches the RAM; bus stays parked.
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mem_ack) begin
                        if (!we_q) begin
                            rdata_q <= bus.mem_dout;
                        end
                        state_q    <= RELEASE;
                        mem_cs_q   <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= PARK_ADDR;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q      <= 1'b1;
                        rdata_q    <= '0;
                        state_q    <= RELEASE;
                        mem_cs_q   <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= PARK_ADDR;
                    end
                end

                RELEASE: begin
                    if (!bus.mem_ack) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // In IDLE the stall must follow the request within the same cycle.
    assign bus.cpu_stall = (state_q == IDLE) ? bus.cpu_req : (state_q != DONE);
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;

endmodule
